// File: rtl/dmem_access_master.sv
// Data-memory initiator: sized loads and stores on a word-only memory, with read-modify-write
// for sub-word stores. Define DMEM_ALIGN_CHECK_EN to reject misaligned requests with resp_err.
module dmem_access_master #(
  parameter int unsigned WORD_LEN  = 32,
  parameter int unsigned RESP_HOLD = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  input  logic                resp_ack,
  output logic                resp_valid,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic                mem_write_en,
  output logic                mem_read_en,
  output logic [WORD_LEN-1:0] mem_address,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StLoad, StStore, StRmwRd, StRmwWr, StResp} state_e;

  state_e              state_q, state_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic [WORD_LEN-1:0] merge_q, merge_d;
  logic [WORD_LEN-1:0] rdata_q, rdata_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;

  logic [1:0]          req_size_n;
  logic [WORD_LEN-1:0] req_addr_n;
  logic [4:0]          lane_sh;
  logic [WORD_LEN-1:0] lane_low, lane_mask, merged, load_val;

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic misaligned;
  assign misaligned = (req_size_n == 2'b01 && req_addr[0]) ||
                      (req_size_n == 2'b10 && req_addr[1:0] != 2'b00);
`endif

  // Reserved size folds to word; misaligned addresses snap down to natural alignment.
  always_comb begin
    req_size_n = (req_size == 2'b11) ? 2'b10 : req_size;
    req_addr_n = req_addr;
    if (req_size_n == 2'b01) req_addr_n = {req_addr[WORD_LEN-1:1], 1'b0};
    if (req_size_n == 2'b10) req_addr_n = {req_addr[WORD_LEN-1:2], 2'b00};
  end

  // Big-endian lanes: byte offset 0 sits in the top byte, so the shift is (3 - offset) * 8.
  always_comb begin
    lane_sh   = (size_q == 2'b00) ? {~addr_q[1:0], 3'b000} : {~addr_q[1], 4'b0000};
    lane_low  = (size_q == 2'b00) ? WORD_LEN'(8'hFF) : WORD_LEN'(16'hFFFF);
    lane_mask = lane_low << lane_sh;
    merged    = (merge_q & ~lane_mask) | ((wdata_q & lane_low) << lane_sh);
    case (size_q)
      2'b00:   load_val = signed_q ? {{(WORD_LEN-8){mem_rdata[lane_sh+7]}}, mem_rdata[lane_sh +: 8]}
                                   : {{(WORD_LEN-8){1'b0}}, mem_rdata[lane_sh +: 8]};
      2'b01:   load_val = signed_q ? {{(WORD_LEN-16){mem_rdata[lane_sh+15]}}, mem_rdata[lane_sh +: 16]}
                                   : {{(WORD_LEN-16){1'b0}}, mem_rdata[lane_sh +: 16]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    size_d   = size_q;
    signed_d = signed_q;
`ifdef DMEM_ALIGN_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d   = req_addr_n;
          size_d   = req_size_n;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          if (!req_write)                state_d = StLoad;
          else if (req_size_n == 2'b10)  state_d = StStore;
          else                           state_d = StRmwRd;
`ifdef DMEM_ALIGN_CHECK_EN
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
`endif
        end
      end
      StLoad: begin
        rdata_d = load_val;
        state_d = StResp;
      end
      StStore: state_d = StResp;
      StRmwRd: begin
        merge_d = mem_rdata;
        state_d = StRmwWr;
      end
      StRmwWr: state_d = StResp;
      StResp: begin
        if (RESP_HOLD == 0 || resp_ack) begin
          state_d = StIdle;
`ifdef DMEM_ALIGN_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Strobes are masked by rst so an abandoned access never writes.
  always_comb begin
    req_ready    = (state_q == StIdle);
    resp_valid   = (state_q == StResp);
    resp_rdata   = rdata_q;
    mem_read_en  = !rst && (state_q == StLoad || state_q == StRmwRd);
    mem_write_en = !rst && (state_q == StStore || state_q == StRmwWr);
    mem_address  = '0;
    mem_wdata    = '0;
    if (state_q == StLoad || state_q == StStore || state_q == StRmwRd || state_q == StRmwWr) begin
      mem_address = {addr_q[WORD_LEN-1:2], 2'b00};
    end
    if (state_q == StStore) mem_wdata = wdata_q;
    if (state_q == StRmwWr) mem_wdata = merged;
`ifdef DMEM_ALIGN_CHECK_EN
    resp_err     = err_q;
`else
    resp_err     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_dmem_access_master.sv
// Self-checking bench for dmem_access_master: directed plan cases, reset abandonment and
// randomized traffic against a byte-array reference model.
module tb_dmem_access_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed, resp_ack;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_write_en, mem_read_en;
  logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_access_master dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_ack    (resp_ack),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_write_en(mem_write_en),
    .mem_read_en (mem_read_en),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory: 256 bytes, words below 0x20 read as zero and ignore writes.
  logic [31:0] smem [0:63] = '{default: 32'h0};
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          overlap_cnt = 0;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;

  assign mem_rdata = (mem_address < 32) ? 32'h0 : smem[mem_address[7:2]];

  always @(posedge clk) begin
    if (mem_write_en) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= mem_address;
      last_wdata <= mem_wdata;
      if (mem_address >= 32) smem[mem_address[7:2]] <= mem_wdata;
    end
    if (mem_read_en) rd_cnt <= rd_cnt + 1;
  end

  always @(negedge clk) begin
    if (mem_write_en && mem_read_en) overlap_cnt <= overlap_cnt + 1;
  end

  // Reference model: memory as big-endian bytes.
  logic [7:0] ref_bytes [0:255] = '{default: 8'h0};

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx], ref_bytes[4*idx+1], ref_bytes[4*idx+2], ref_bytes[4*idx+3]};
  endfunction

  task automatic model_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat, output logic err,
                           output int nwr);
    int nbytes, base;
    logic [31:0] val;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = 1'b0; rd = 32'h0; nwr = 0; lat = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    if (int'(a) % nbytes != 0) begin
      err = 1'b1; lat = 1;
      return;
    end
`endif
    base = int'(a) - (int'(a) % nbytes);
    if (wr) begin
      for (int i = 0; i < nbytes; i++) begin
        if (base + i >= 32) ref_bytes[base+i] = 8'((wd >> (8 * (nbytes - 1 - i))) & 32'hFF);
      end
      lat = (nbytes == 4) ? 2 : 3;
      nwr = 1;
    end else begin
      val = 32'h0;
      for (int i = 0; i < nbytes; i++) val = (val << 8) | {24'h0, ref_bytes[base+i]};
      if (sg && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
      rd = val;
    end
  endtask

  // Drives one request and measures the response cycle (accept edge = cycle 0).
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output int nwr, output int nrd);
    int guard, wr0, rd0;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    wr0 = wr_cnt; rd0 = rd_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    nwr   = wr_cnt - wr0;
    nrd   = rd_cnt - rd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); else n_pass++;
    n_checks++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err got %b want 0", resp_err); else n_pass++;
    n_checks++; if (mem_write_en !== 1'b0) $display("FAIL reset_write_en got %b want 0", mem_write_en); else n_pass++;
    n_checks++; if (mem_read_en !== 1'b0) $display("FAIL reset_read_en got %b want 0", mem_read_en); else n_pass++;
    n_checks++; if (mem_address !== 32'h0) $display("FAIL reset_address got %h want 0", mem_address); else n_pass++;
    n_checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", mem_wdata); else n_pass++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_directed();
    int lat, nwr, nrd, ml, mw;
    logic [31:0] rd, mr;
    logic err, me;
    model_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, mr, ml, me, mw);
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, lat, rd, err, nwr, nrd);
    n_checks++; if (nwr !== 1) $display("FAIL dir_wstore_pulses got %0d want 1", nwr); else n_pass++;
    n_checks++; if (last_waddr !== 32'h40) $display("FAIL dir_wstore_addr got %h want 00000040", last_waddr); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL dir_wstore_latency got %0d want 2", lat); else n_pass++;
    model_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, mr, ml, me, mw);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, lat, rd, err, nwr, nrd);
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL dir_wload_data got %h want deadbeef", rd); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL dir_wload_latency got %0d want 2", lat); else n_pass++;
    model_req(1'b0, 2'd0, 1'b1, 32'h41, 32'h0, mr, ml, me, mw);
    issue(1'b0, 2'd0, 1'b1, 32'h41, 32'h0, lat, rd, err, nwr, nrd);
    n_checks++; if (rd !== 32'hFFFFFFAD) $display("FAIL dir_bload_signed got %h want ffffffad", rd); else n_pass++;
    model_req(1'b0, 2'd0, 1'b0, 32'h43, 32'h0, mr, ml, me, mw);
    issue(1'b0, 2'd0, 1'b0, 32'h43, 32'h0, lat, rd, err, nwr, nrd);
    n_checks++; if (rd !== 32'h000000EF) $display("FAIL dir_bload_unsigned got %h want 000000ef", rd); else n_pass++;
    model_req(1'b1, 2'd0, 1'b0, 32'h42, 32'h12, mr, ml, me, mw);
    issue(1'b1, 2'd0, 1'b0, 32'h42, 32'h12, lat, rd, err, nwr, nrd);
    n_checks++; if (last_wdata !== 32'hDEAD12EF) $display("FAIL dir_bstore_merge got %h want dead12ef", last_wdata); else n_pass++;
    n_checks++; if (lat !== 3) $display("FAIL dir_bstore_latency got %0d want 3", lat); else n_pass++;
    n_checks++; if (nrd !== 1 || nwr !== 1) $display("FAIL dir_bstore_rmw got rd=%0d wr=%0d want 1/1", nrd, nwr); else n_pass++;
    model_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, mr, ml, me, mw);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, lat, rd, err, nwr, nrd);
    n_checks++; if (rd !== 32'hDEAD12EF) $display("FAIL dir_reload got %h want dead12ef", rd); else n_pass++;
    model_req(1'b0, 2'd1, 1'b1, 32'h40, 32'h0, mr, ml, me, mw);
    issue(1'b0, 2'd1, 1'b1, 32'h40, 32'h0, lat, rd, err, nwr, nrd);
    n_checks++; if (rd !== 32'hFFFFDEAD) $display("FAIL dir_hload_signed got %h want ffffdead", rd); else n_pass++;
    model_req(1'b1, 2'd1, 1'b0, 32'h40, 32'h5678, mr, ml, me, mw);
    issue(1'b1, 2'd1, 1'b0, 32'h40, 32'h5678, lat, rd, err, nwr, nrd);
    n_checks++; if (smem[16] !== 32'h567812EF) $display("FAIL dir_hstore_word got %h want 567812ef", smem[16]); else n_pass++;
  endtask

  task automatic test_misaligned();
    int lat, nwr, nrd, ml, mw;
    logic [31:0] rd, mr;
    logic err, me;
    model_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, mr, ml, me, mw);
    issue(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, lat, rd, err, nwr, nrd);
`ifdef DMEM_ALIGN_CHECK_EN
    n_checks++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL mis_err got err=%b data=%h want 1/0", err, rd); else n_pass++;
    n_checks++; if (lat !== 1) $display("FAIL mis_latency got %0d want 1", lat); else n_pass++;
    n_checks++; if (nrd !== 0) $display("FAIL mis_no_read got %0d want 0", nrd); else n_pass++;
`else
    n_checks++; if (err !== 1'b0 || rd !== 32'h567812EF) $display("FAIL mis_aligned_read got err=%b data=%h want 0/567812ef", err, rd); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL mis_latency got %0d want 2", lat); else n_pass++;
    n_checks++; if (nrd !== 1) $display("FAIL mis_read_cycles got %0d want 1", nrd); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_rmw();
    int wr0;
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h44; req_wdata = 32'hA5;
    req_valid = 1'b1;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n_checks++; if (mem_read_en !== 1'b1) $display("FAIL rstmid_rmw_read got %b want 1", mem_read_en); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (mem_write_en !== 1'b0) $display("FAIL rstmid_strobe got %b want 0", mem_write_en); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0)
      $display("FAIL rstmid_resp_side got rdy=%b vld=%b data=%h want 1/0/0", req_ready, resp_valid, resp_rdata);
    else n_pass++;
    n_checks++; if (mem_address !== 32'h0 || mem_wdata !== 32'h0 || mem_read_en !== 1'b0)
      $display("FAIL rstmid_mem_side got addr=%h wd=%h rd=%b want 0/0/0", mem_address, mem_wdata, mem_read_en);
    else n_pass++;
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (wr_cnt !== wr0) $display("FAIL rstmid_no_write got %0d want %0d", wr_cnt, wr0); else n_pass++;
    n_checks++; if (smem[17] !== ref_word(17)) $display("FAIL rstmid_mem got %h want %h", smem[17], ref_word(17)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, nwr, nrd, ml, mw;
    logic [31:0] rd, mr;
    logic err, me;
    model_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, mr, ml, me, mw);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, lat, rd, err, nwr, nrd);
    n_checks++; if (req_ready !== 1'b0) $display("FAIL b2b_busy_in_resp got %b want 0", req_ready); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL b2b_idle_after_resp got rdy=%b vld=%b want 1/0", req_ready, resp_valid);
    else n_pass++;
    model_req(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, mr, ml, me, mw);
    issue(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, lat, rd, err, nwr, nrd);
    n_checks++; if (rd !== mr || lat !== 2) $display("FAIL b2b_second got %h/%0d want %h/2", rd, lat, mr); else n_pass++;
  endtask

  task automatic test_random();
    int lat, nwr, nrd, ml, mw;
    logic [31:0] rd, mr, a, wd;
    logic err, me, wr, sg;
    logic [1:0] sz;
    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 255);
      wd = $urandom;
      model_req(wr, sz, sg, a, wd, mr, ml, me, mw);
      issue(wr, sz, sg, a, wd, lat, rd, err, nwr, nrd);
      n_checks++; if (lat !== ml) $display("FAIL rnd_latency #%0d got %0d want %0d", n, lat, ml); else n_pass++;
      n_checks++; if (rd !== mr) $display("FAIL rnd_rdata #%0d got %h want %h", n, rd, mr); else n_pass++;
      n_checks++; if (err !== me) $display("FAIL rnd_err #%0d got %b want %b", n, err, me); else n_pass++;
      n_checks++; if (nwr !== mw) $display("FAIL rnd_write_pulses #%0d got %0d want %0d", n, nwr, mw); else n_pass++;
      n_checks++; if (smem[a[7:2]] !== ref_word(int'(a[7:2])))
        $display("FAIL rnd_mem #%0d got %h want %h", n, smem[a[7:2]], ref_word(int'(a[7:2])));
      else n_pass++;
    end
    n_checks++; if (overlap_cnt !== 0) $display("FAIL rd_wr_overlap got %0d want 0", overlap_cnt); else n_pass++;
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ack = 1'b0;
    test_reset();
    test_directed();
    test_misaligned();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_master.md
Name: dmem_access_master

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the pipeline MEM stage and drives the data memory's writeEn/readEn/address/dataIn.
- Reads the memory's combinational dataOut.
- Adds byte/halfword/word access sizes, sign/zero extension and read-modify-write for sub-word stores, on top of the word-only memory.
- Holds the pipeline off via req_ready while an access is in flight.

Parameters:
- WORD_LEN, 32, data/address width; must match the data memory word width.
- RESP_HOLD, 0, 0 = resp_valid is a one-cycle pulse; 1 = resp_valid holds until resp_ack.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  WORD_LEN  byte address
- req_wdata  in  WORD_LEN  store data, right-justified
- resp_ack  in  1  consumer accepts response (used only when RESP_HOLD=1)
- resp_valid  out  1  response present
- resp_rdata  out  WORD_LEN  load result, extended; 0 for stores
- resp_err  out  1  misaligned request (only with DMEM_ALIGN_CHECK_EN)
- mem_write_en  out  1  to memory writeEn
- mem_read_en  out  1  to memory readEn
- mem_address  out  WORD_LEN  to memory address; always word-aligned (low 2 bits 0)
- mem_wdata  out  WORD_LEN  to memory dataIn
- mem_rdata  in  WORD_LEN  from memory dataOut, combinational

Behaviour:
- Reset values: state IDLE, req_ready=1 (after reset), resp_valid=0, resp_rdata=0, resp_err=0, mem_write_en=0, mem_read_en=0, mem_address=0, mem_wdata=0.
- Reset mid-operation abandons the access. A write strobe never fires in the cycle rst is high.
- Byte order is big-endian within a word: offset 0 = bits[31:24], offset 3 = bits[7:0]. Halfword offset 0 = bits[31:16], offset 2 = bits[15:0].
- State machine:
  - IDLE: req_ready=1. On req_valid, latch the request into registers. Next state by request type:
    - load → LOAD
    - word store → STORE
    - sub-word store → RMW_RD
    - misaligned (with check) → RESP with err
  - LOAD: mem_read_en=1, mem_address = addr & ~3. At the clock edge, capture the selected lane of mem_rdata, extend to WORD_LEN, go to RESP.
  - STORE: mem_write_en=1, mem_wdata = wdata, go to RESP.
  - RMW_RD: mem_read_en=1, capture mem_rdata into a merge register, go to RMW_WR.
  - RMW_WR: mem_write_en=1. mem_wdata = merge register with the target byte/halfword lane replaced by wdata[7:0]/[15:0]; other lanes unchanged. Go to RESP.
  - RESP: resp_valid=1. With RESP_HOLD=0, return to IDLE next cycle. With RESP_HOLD=1, stay until resp_ack=1.
- Latency (accept edge = cycle 0, RESP_HOLD=0):
  - load and word store: resp_valid in cycle 2
  - sub-word store: resp_valid in cycle 3
  - misaligned: resp_valid in cycle 1
- Back-to-back: a new request is accepted in the cycle after RESP, i.e. no overlap.
- mem_write_en and mem_read_en are never high in the same cycle.
- mem_write_en is high for exactly one cycle per store.
- Memory words at addresses 0–31 read as 0. The master does not special-case them: RMW into that region merges against 0.
- req_size 11 behaves exactly as 10.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: halfword with addr[0]=1, or word with addr[1:0]≠0, issues no memory access. Response in cycle 1 with resp_err=1 and resp_rdata=0.
- Undefined: resp_err tied 0. Misaligned low address bits are cleared to the natural alignment (halfword addr[0]=0, word addr[1:0]=0) and the access proceeds normally.

Test Plan:
- Word store 0xDEADBEEF to 0x40, then word load 0x40 → single mem_write_en pulse with mem_address=0x40; load resp_rdata=0xDEADBEEF in cycle 2.
- After the above, byte loads 0x41 signed and 0x43 unsigned → 0xFFFFFFAD and 0x000000EF.
- Byte store 0x12 to 0x42 → RMW_RD then RMW_WR with mem_wdata=0xDEAD12EF; subsequent word load 0x40 = 0xDEAD12EF; resp_valid in cycle 3.
- Halfword signed load 0x40 after the above → 0xFFFFDEAD. Halfword store 0x5678 to 0x40 → word becomes 0x567812EF.
- Assert rst during RMW_WR-preceding RMW_RD cycle → no mem_write_en pulse, memory word unchanged, outputs at reset values next cycle.
- With DMEM_ALIGN_CHECK_EN, word load at 0x42 → resp_err=1, resp_rdata=0 in cycle 1, mem_read_en never asserted. Without it, the same request reads word 0x40.
